// File: rtl/xort_mon_pkg.sv
// Shared encodings for the XOR-T output monitor: model states, error codes
// and the input-absorb rule of the cell's two storage loops.
package xort_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HAVE_A = 2'd1,
    ST_HAVE_B = 2'd2,
    ST_BOTH   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISSED   = 2'd1;
  localparam logic [1:0] ERR_SPURIOUS = 2'd2;
  localparam logic [1:0] ERR_DOUBLE   = 2'd3;

  // Each loop stores at most one flux quantum, so input pulses only ever set bits.
  function automatic state_t absorb(input state_t s, input logic pa, input logic pb);
    logic ha;
    logic hb;
    ha = (s == ST_HAVE_A) || (s == ST_BOTH) || pa;
    hb = (s == ST_HAVE_B) || (s == ST_BOTH) || pb;
    return state_t'({hb, ha});
  endfunction

endpackage

// File: rtl/toggle_pulse_det.sv
// Toggle-to-pulse converter for one SFQ line: optional 2-flop synchronizer
// (XORT_MON_SYNC_EN) followed by a previous-sample compare, registered pulse out.
module toggle_pulse_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic samp;
  logic prev;

`ifdef XORT_MON_SYNC_EN
  logic meta;
  logic sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= din;
      sync <= din;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  assign samp = sync;
`else
  assign samp = din;
`endif

  // Reset captures the live level so the first sample after reset is not a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= din;
      pulse <= 1'b0;
    end else begin
      prev  <= samp;
      pulse <= samp ^ prev;
    end
  end

endmodule

// File: rtl/mitll_xort_mon.sv
// Output-side checker for the clocked XOR-T cell: cycle-accurate cell model plus
// an expected-pulse window tracker. XORT_MON_SYNC_EN adds input synchronizers.
module mitll_xort_mon #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             sfq_clk,
  input  logic             out,
  output logic [1:0]       state,
  output logic             exp_pulse,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  import xort_mon_pkg::*;

  localparam logic [7:0]       WIN_LOAD = 8'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic pa, pb, pc, po;

  toggle_pulse_det u_det_a (.clk(clk), .rst(rst), .din(a),       .pulse(pa));
  toggle_pulse_det u_det_b (.clk(clk), .rst(rst), .din(b),       .pulse(pb));
  toggle_pulse_det u_det_c (.clk(clk), .rst(rst), .din(sfq_clk), .pulse(pc));
  toggle_pulse_det u_det_o (.clk(clk), .rst(rst), .din(out),     .pulse(po));

  state_t     st;
  state_t     st_clk;
  state_t     st_nxt;
  logic       exp_nxt;
  logic [7:0] win;
  logic       pending;
  logic [7:0] win_nxt;
  logic       pend_nxt;
  logic       err_nxt;
  logic [1:0] code_nxt;
  logic       ok_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // The clock pulse reads the pre-sample state; data pulses land on the post-clock state.
  always_comb begin
    exp_nxt = pc && ((st == ST_HAVE_A) || (st == ST_HAVE_B));
    st_clk  = pc ? ST_IDLE : st;
    st_nxt  = absorb(st_clk, pa, pb);
  end

  always_comb begin
    err_nxt  = 1'b0;
    code_nxt = ERR_NONE;
    ok_hit   = 1'b0;
    pend_nxt = pending;
    win_nxt  = win;
    if (exp_nxt) begin
      if (pending) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_DOUBLE;
      end
      if (po) begin
        ok_hit   = 1'b1;
        pend_nxt = 1'b0;
        win_nxt  = 8'd0;
      end else begin
        pend_nxt = 1'b1;
        win_nxt  = WIN_LOAD;
      end
    end else if (po) begin
      if (pending) begin
        ok_hit   = 1'b1;
        pend_nxt = 1'b0;
        win_nxt  = 8'd0;
      end else begin
        err_nxt  = 1'b1;
        code_nxt = ERR_SPURIOUS;
      end
    end else if (pending) begin
      // Expiry on the last window cycle makes MISSED land exactly WINDOW after exp_pulse.
      if (win <= 8'd1) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_MISSED;
        pend_nxt = 1'b0;
        win_nxt  = 8'd0;
      end else begin
        win_nxt = win - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      exp_pulse <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      ok_cnt    <= '0;
      err_cnt   <= '0;
      pending   <= 1'b0;
      win       <= 8'd0;
    end else begin
      st        <= st_nxt;
      exp_pulse <= exp_nxt;
      err       <= err_nxt;
      err_code  <= code_nxt;
      pending   <= pend_nxt;
      win       <= win_nxt;
      if (ok_hit)  ok_cnt  <= sat_inc(ok_cnt);
      if (err_nxt) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mitll_xort_mon.sv
// Scoreboard bench for mitll_xort_mon: a flux-storage model predicts exp_pulse
// and error strobes per sample, a negedge monitor pops and compares them.
module tb_mitll_xort_mon;

  localparam int WINDOW  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int HMAX    = 4096;
  localparam logic [1:0] C_MISSED   = 2'd1;
  localparam logic [1:0] C_SPURIOUS = 2'd2;
  localparam logic [1:0] C_DOUBLE   = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, sfq_clk = 1'b0, out = 1'b0;
  logic [1:0]       state;
  logic             exp_pulse;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] err_cnt;

  mitll_xort_mon #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sfq_clk(sfq_clk), .out(out),
    .state(state), .exp_pulse(exp_pulse), .err(err), .err_code(err_code),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [1:0] code;
  } err_ev_t;

  int      exp_q[$];
  err_ev_t err_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which storage loops hold a quantum, and the cycle by which out must toggle.
  bit ha, hb;
  int deadline = -1;
  int ok_m = 0, err_m = 0;
  int  hist_st [HMAX];
  int  hist_ok [HMAX];
  int  hist_err[HMAX];
  bit  hist_v  [HMAX];

  task automatic checkValue(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_err(input int t, input logic [1:0] code);
    err_ev_t ev;
    ev.cyc  = t;
    ev.code = code;
    err_q.push_back(ev);
    if (err_m < CNT_MAX) err_m++;
  endtask

  task automatic model_step(input int t, input bit ta, input bit tb, input bit tc, input bit to);
    bit e;
    e = tc && (ha != hb);
    if (tc) begin
      ha = 1'b0;
      hb = 1'b0;
    end
    if (ta) ha = 1'b1;
    if (tb) hb = 1'b1;
    if (e) begin
      exp_q.push_back(t);
      if (deadline >= 0) push_err(t, C_DOUBLE);
      if (to) begin
        if (ok_m < CNT_MAX) ok_m++;
        deadline = -1;
      end else begin
        deadline = t + WINDOW;
      end
    end else if (to) begin
      if (deadline >= 0) begin
        if (ok_m < CNT_MAX) ok_m++;
        deadline = -1;
      end else begin
        push_err(t, C_SPURIOUS);
      end
    end else if (deadline == t) begin
      push_err(t, C_MISSED);
      deadline = -1;
    end
    if (t < HMAX) begin
      hist_st[t]  = int'(ha) + 2 * int'(hb);
      hist_ok[t]  = ok_m;
      hist_err[t] = err_m;
      hist_v[t]   = 1'b1;
    end
  endtask

  // A toggle driven at negedge of cycle P is seen by the monitor after posedge P+2.
  task automatic applyStimulus(input bit ta, input bit tb, input bit tc, input bit to);
    @(negedge clk);
    if (ta) a = ~a;
    if (tb) b = ~b;
    if (tc) sfq_clk = ~sfq_clk;
    if (to) out = ~out;
    model_step(cyc + 2, ta, tb, tc, to);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    int      r;
    int      keep_e[$];
    err_ev_t keep_r[$];
    @(negedge clk);
    rst = 1'b1;
    r = cyc;
    foreach (exp_q[i]) if (exp_q[i] <= r) keep_e.push_back(exp_q[i]);
    foreach (err_q[i]) if (err_q[i].cyc <= r) keep_r.push_back(err_q[i]);
    exp_q = keep_e;
    err_q = keep_r;
    ha = 1'b0;
    hb = 1'b0;
    deadline = -1;
    ok_m = 0;
    err_m = 0;
    for (int t = r + 1; t <= r + 4; t++) model_step(t, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    if (cyc < HMAX && hist_v[cyc]) begin
      checkValue({tag, "_state"},   int'(state),   hist_st[cyc]);
      checkValue({tag, "_ok_cnt"},  int'(ok_cnt),  hist_ok[cyc]);
      checkValue({tag, "_err_cnt"}, int'(err_cnt), hist_err[cyc]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkValue("exp_pulse_unexpected", 1, 0);
      end else begin
        checkValue("exp_pulse_cycle", cyc, exp_q.pop_front());
      end
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      checkValue("exp_pulse_missing", 0, 1);
      void'(exp_q.pop_front());
    end
    if (err === 1'b1) begin
      if (err_q.size() == 0) begin
        checkValue("err_unexpected_code", int'(err_code), 0);
      end else begin
        err_ev_t ev;
        ev = err_q.pop_front();
        checkValue("err_cycle", cyc, ev.cyc);
        checkValue("err_code", int'(err_code), int'(ev.code));
      end
    end else if (err_q.size() > 0 && err_q[0].cyc <= cyc) begin
      checkValue("err_missing", 0, int'(err_q[0].code));
      void'(err_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    checkOutput("reset");
    checkValue("reset_exp_pulse", int'(exp_pulse), 0);
    checkValue("reset_err_code", int'(err_code), 0);

    // a, then clock, then out three samples later: one match
    idle(4);
    applyStimulus(1, 0, 0, 0);
    idle(4);
    applyStimulus(0, 0, 1, 0);
    idle(2);
    applyStimulus(0, 0, 0, 1);
    idle(3);
    checkOutput("t1");
    checkValue("t1_ok", int'(ok_cnt), 1);
    checkValue("t1_err", int'(err_cnt), 0);

    // a and b give BOTH, clock yields nothing, a later out is spurious
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    idle(2);
    checkValue("t2_both", int'(state), 3);
    applyStimulus(0, 0, 1, 0);
    idle(2);
    checkValue("t2_idle", int'(state), 0);
    applyStimulus(0, 0, 0, 1);
    idle(2);
    checkValue("t2_err_cnt", int'(err_cnt), 1);

    // a twice, clock, no out: MISSED after the window
    applyStimulus(1, 0, 0, 0);
    idle(1);
    applyStimulus(1, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, 0);
    idle(10);
    checkValue("t3_err_cnt", int'(err_cnt), 2);

    // a with clock in the same sample: IDLE pre-state, HAVE_A after
    applyStimulus(1, 0, 1, 0);
    idle(2);
    checkValue("t4_have_a", int'(state), 1);
    applyStimulus(0, 0, 1, 0);
    idle(1);
    applyStimulus(0, 0, 0, 1);
    idle(2);
    checkValue("t4_ok", int'(ok_cnt), 2);

    // zero-delay DUT: out toggles with the clock
    applyStimulus(0, 1, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, 1);
    idle(2);
    checkValue("t5_ok", int'(ok_cnt), 3);
    checkOutput("t5");

    // two expectations inside one window: DOUBLE, then reset drops the window
    applyStimulus(1, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, 0);
    idle(1);
    applyStimulus(1, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, 0);
    idle(2);
    checkValue("t6_err_cnt", int'(err_cnt), 3);
    doReset();
    idle(12);
    checkOutput("t6_post");
    checkValue("t6_ok_zero", int'(ok_cnt), 0);
    checkValue("t6_err_zero", int'(err_cnt), 0);
    checkValue("t6_err_low", int'(err), 0);

    // 20 spurious pulses saturate the 4-bit error counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 1);
      idle(1);
    end
    idle(2);
    checkValue("t7_err_sat", int'(err_cnt), 15);

    // randomized traffic, out biased toward following an expectation
    for (int blk = 0; blk < 3; blk++) begin
      doReset();
      for (int i = 0; i < 200; i++) begin
        bit ra, rb, rc, ro;
        ra = ($urandom_range(4) == 0);
        rb = ($urandom_range(4) == 0);
        rc = ($urandom_range(5) == 0);
        ro = (deadline >= 0) ? ($urandom_range(3) == 0) : ($urandom_range(24) == 0);
        applyStimulus(ra, rb, rc, ro);
        if (i % 8 == 7) checkOutput("rand");
      end
    end

    idle(WINDOW + 4);
    checkOutput("drain");
    checkValue("exp_queue_empty", exp_q.size(), 0);
    checkValue("err_queue_empty", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mitll_xort_mon.md
# mitll_xort_mon

Synthesizable monitor/checker for the clocked XOR cell's output side, running on a fast sampling clock. It observes the toggle-encoded SFQ lines (every level change on `a`, `b`, `sfq_clk`, `out` is one pulse) and runs a cycle-accurate reference model of the XOR-T cell. It verifies each output pulse against that model and keeps match and error counts. It sits after the stimulus driver and DUT, on the bench or on chip-test FPGA logic, as the receiving end of the same pulse protocol.

## Interface
- `WINDOW`, 8: sample cycles after an expected pulse in which `out` must toggle (1..255)
- `CNT_W`, 16: width of `ok_cnt` and `err_cnt`
- `clk`  in  1  sampling clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `a`, `b`  in  1  toggle-encoded data input pulses
- `sfq_clk`  in  1  toggle-encoded SFQ clock pulse line
- `out`  in  1  toggle-encoded DUT output
- `state`  out  2  model state: 0 IDLE, 1 HAVE_A, 2 HAVE_B, 3 BOTH
- `exp_pulse`  out  1  1-cycle strobe: the model expects an output pulse
- `err`  out  1  1-cycle error strobe
- `err_code`  out  2  valid with `err`: 1 MISSED, 2 SPURIOUS, 3 DOUBLE
- `ok_cnt`, `err_cnt`  out  CNT_W  saturating counters

## Operation
- Previous-sample registers for `a`, `b`, `sfq_clk`, `out`. Pulse detect is `cur != prev`, with at most one pulse per line per sample.
- Model FSM (pulse flags from the same sample):
  - `sfq_clk` pulse is evaluated on the pre-sample state. HAVE_A or HAVE_B asserts `exp_pulse`. Any state goes to IDLE.
  - Input pulses then apply to the post-clock state:
    - IDLE + a → HAVE_A.
    - IDLE + b → HAVE_B.
    - IDLE + a and b together → BOTH.
    - HAVE_A + a → HAVE_A, because the storage loop holds one flux quantum.
    - HAVE_A + b → BOTH.
    - HAVE_B is symmetric to HAVE_A.
    - BOTH + any input → BOTH.
- Window tracker: a down-counter `win` (8 bits) plus a `pending` flag.
  - `exp_pulse` loads `win=WINDOW` and sets `pending`.
  - `out` pulse while `pending`: `ok_cnt`+1, clear `pending`.
  - `out` pulse while not pending: `err`, code SPURIOUS.
  - `win` reaches 0 while `pending`: `err`, code MISSED, clear `pending`.
  - `exp_pulse` while already `pending`: `err`, code DOUBLE (the earlier expectation counts as missed). Reload the window.
- Same-cycle cases:
  - `out` pulse and `exp_pulse` together: the new window is satisfied immediately, `ok_cnt`+1. This covers a zero-delay DUT.
  - `out` pulse and window expiry together: counts as a match.
- Counters saturate at all-ones. `err_cnt` increments once per `err` strobe.

## Timing
- Reset values:
  - `state`=IDLE, `exp_pulse`=0, `err`=0, `err_code`=0, counters=0.
  - `pending`=0, `win`=0.
  - Previous-sample registers load the current input levels, so there are no false pulses after reset.
- Latency:
  - Input toggle sampled at edge N → pulse flag and `state` update at N+1.
  - `exp_pulse` at N+1.
- A MISSED error is reported exactly `WINDOW` cycles after `exp_pulse`.
- Reset mid-operation wins over everything: it discards the pending window, with no MISSED report.
- Inputs must be held ≥1 sample period between toggles. Faster toggling is out of scope and undetected.

## Configuration
- `XORT_MON_SYNC_EN`: when defined, a 2-flop synchronizer is inserted on each of the four inputs ahead of edge detect. This adds 2 cycles to every latency above and is intended for asynchronous chip-test inputs.
- When undefined, the inputs are treated as synchronous to `clk`.

## Structure
- Shared package `xort_mon_pkg`:
  - State encoding constants `ST_IDLE`, `ST_HAVE_A`, `ST_HAVE_B`, `ST_BOTH`.
  - Error code constants `ERR_MISSED`, `ERR_SPURIOUS`, `ERR_DOUBLE`.
- One sub-module, `toggle_pulse_det`: optional synchronizer plus previous-sample edge detect, one instance per line.

## Test plan
- Toggle a at cycle 5, then sfq_clk at 10, then out at 13 (WINDOW=8) → `exp_pulse` at 11, `ok_cnt`=1, no `err`.
- Toggle a, then b, then sfq_clk → state BOTH then IDLE, no `exp_pulse`. A later out toggle gives `err`/SPURIOUS and `err_cnt`=1.
- Toggle a twice, then sfq_clk, with no out → `exp_pulse`. `err`/MISSED exactly 8 cycles later.
- Toggle a and sfq_clk in the same sample → no `exp_pulse` from the IDLE pre-state, `state`=HAVE_A afterwards.
- Hold sfq_clk pulse pairs with pending a, no out, second expectation inside the window → `err`/DOUBLE. Reset mid-window → no MISSED, all outputs zero.
- Force `err_cnt` to all-ones with CNT_W=4 and generate 20 spurious pulses → `err_cnt` stays 15.
